// File: rtl/capture_pkg.sv
// rtl/capture_pkg.sv - shared types and sizes for the capture read-side scheduler
package capture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    BURST,
    END,
    HALT
  } state_t;

  localparam int FIFO_DEPTH      = 8192;
  localparam int HALF_FULL_LEVEL = 4096;
  localparam int GPIF_W          = 16;
  localparam int SAMPLE_W        = 10;

endpackage

// File: rtl/gpif_output_stage.sv
// rtl/gpif_output_stage.sv - registered GPIF data/valid pipeline with 10-bit test pattern
module gpif_output_stage
  import capture_pkg::*;
(
  input  logic                clk,
  input  logic                i_reset,
  input  logic                i_ack,
  input  logic                i_test_mode,
  input  logic                i_pattern_clr,
  input  logic [SAMPLE_W-1:0] i_fifo_data,
  output logic [GPIF_W-1:0]   o_gpif_data,
  output logic                o_gpif_write
);

  logic [SAMPLE_W-1:0] r_pattern;
  logic [GPIF_W-1:0]   r_gpif_data;
  logic                r_gpif_write;
  logic [SAMPLE_W-1:0] w_sample;

  assign w_sample = i_test_mode ? r_pattern : i_fifo_data;

  // Data is sampled every cycle; only gpifWrite qualifies it for the host.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_pattern    <= '0;
      r_gpif_data  <= '0;
      r_gpif_write <= 1'b0;
    end else begin
      r_gpif_write <= i_ack;
      r_gpif_data  <= {{(GPIF_W - SAMPLE_W){1'b0}}, w_sample};
      if (i_pattern_clr) begin
        r_pattern <= '0;
      end else if (i_ack) begin
        r_pattern <= r_pattern + SAMPLE_W'(1);
      end
    end
  end

  assign o_gpif_data  = r_gpif_data;
  assign o_gpif_write = r_gpif_write;

endmodule

// File: rtl/capture_transfer_scheduler.sv
// rtl/capture_transfer_scheduler.sv - arms capture, gates bursts on half-full and DMA ready, drains to GPIF
module capture_transfer_scheduler
  import capture_pkg::*;
#(
  parameter int BURST_LEN = 4096,
  parameter int COUNT_W   = 16
) (
  input  logic                outputClock,
  input  logic                reset,
  input  logic                hostCollect,
  input  logic                testMode,
  input  logic                dmaReady,
  input  logic [SAMPLE_W-1:0] fifoData,
  input  logic                fifoEmpty,
  input  logic                fifoHalfFull,
  input  logic                fifoFull,
  output logic                fifoAck,
  output logic                fifoNReady,
  output logic [GPIF_W-1:0]   gpifData,
  output logic                gpifWrite,
  output logic                overflow,
  output logic                underflow,
  output logic                busy,
  output logic [COUNT_W-1:0]  burstCount
);

  // Word counter is sized for the largest legal burst so any BURST_LEN fits.
  localparam int WC_W = $clog2(HALF_FULL_LEVEL) + 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(BURST_LEN - 1);

  state_t             r_state;
  logic               r_overflow;
  logic               r_underflow;
  logic [COUNT_W-1:0] r_burst_count;
  logic [WC_W-1:0]    r_word_count;

  logic w_ack;
  logic w_halt_after_end;
  logic w_enter_arm;

  assign w_ack            = (r_state == BURST) && !fifoEmpty;
  assign w_halt_after_end = r_overflow || fifoFull;
  assign w_enter_arm      = hostCollect &&
                            ((r_state == IDLE) || ((r_state == END) && !w_halt_after_end));

  always_ff @(posedge outputClock) begin
    if (reset) begin
      r_state       <= IDLE;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
      r_burst_count <= '0;
      r_word_count  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (hostCollect) begin
            r_state       <= ARM;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
            r_burst_count <= '0;
          end
        end
        ARM: begin
          // Priority: a full FIFO halts, then a disarm, then a burst start.
          if (fifoFull) begin
            r_state    <= HALT;
            r_overflow <= 1'b1;
          end else if (!hostCollect) begin
            r_state <= IDLE;
          end else if (fifoHalfFull && dmaReady) begin
            r_state      <= BURST;
            r_word_count <= '0;
          end
        end
        BURST: begin
          if (fifoFull) begin
            r_overflow <= 1'b1;
          end
          if (fifoEmpty) begin
            r_underflow <= 1'b1;
          end else begin
            r_word_count <= r_word_count + WC_W'(1);
            if (r_word_count == WC_LAST) begin
              r_state <= END;
            end
          end
        end
        END: begin
          r_burst_count <= r_burst_count + COUNT_W'(1);
          if (w_halt_after_end) begin
            r_state    <= HALT;
            r_overflow <= 1'b1;
          end else if (hostCollect) begin
            r_state <= ARM;
          end else begin
            r_state <= IDLE;
          end
        end
        HALT: begin
          if (!hostCollect) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  gpif_output_stage u_output_stage (
    .clk          (outputClock),
    .i_reset      (reset),
    .i_ack        (w_ack),
    .i_test_mode  (testMode),
    .i_pattern_clr(w_enter_arm),
    .i_fifo_data  (fifoData),
    .o_gpif_data  (gpifData),
    .o_gpif_write (gpifWrite)
  );

  assign fifoAck    = w_ack;
  assign fifoNReady = (r_state == IDLE) || (r_state == HALT);
  assign busy       = (r_state == BURST) || (r_state == END);
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;
  assign burstCount = r_burst_count;

endmodule

// File: tb/tb_capture_transfer_scheduler.sv
// tb/tb_capture_transfer_scheduler.sv - bench for capture_transfer_scheduler (4096- and 8-word instances)
module tb_capture_transfer_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, hc, tm, dma, empty, hf, full;
  logic [9:0] fdata;
  logic l_ack, l_nr, l_wr, l_ov, l_uf, l_busy;
  logic s_ack, s_nr, s_wr, s_ov, s_uf, s_busy;
  logic [15:0] l_dat, l_bc, s_dat, s_bc;

  capture_transfer_scheduler #(.BURST_LEN(4096), .COUNT_W(16)) u_dut_l (
    .outputClock(clk), .reset(reset), .hostCollect(hc), .testMode(tm), .dmaReady(dma),
    .fifoData(fdata), .fifoEmpty(empty), .fifoHalfFull(hf), .fifoFull(full),
    .fifoAck(l_ack), .fifoNReady(l_nr), .gpifData(l_dat), .gpifWrite(l_wr),
    .overflow(l_ov), .underflow(l_uf), .busy(l_busy), .burstCount(l_bc));

  capture_transfer_scheduler #(.BURST_LEN(8), .COUNT_W(16)) u_dut_s (
    .outputClock(clk), .reset(reset), .hostCollect(hc), .testMode(tm), .dmaReady(dma),
    .fifoData(fdata), .fifoEmpty(empty), .fifoHalfFull(hf), .fifoFull(full),
    .fifoAck(s_ack), .fifoNReady(s_nr), .gpifData(s_dat), .gpifWrite(s_wr),
    .overflow(s_ov), .underflow(s_uf), .busy(s_busy), .burstCount(s_bc));

  int n_chk = 0, n_pass = 0, n_fail = 0;

  // Reference model: phase flags plus words remaining in the current burst.
  bit m_arm[2], m_burst[2], m_gap[2], m_halt[2], m_ov[2], m_uf[2], m_wr[2];
  int m_left[2], m_cnt[2], m_pat[2], m_dat[2];
  int bl[2] = '{4096, 8};

  int  wr_cnt[2];
  bit  chk_en, use_src, ord_en;
  int  src, ord_idx;

  typedef struct {
    bit rst, hc, hf, dma, full, empty;
    bit nr, ack, ov, uf, busy;
  } vec_t;
  vec_t tbl[12];

  function automatic int scr(int i);
    return (i * 37 + 5) % 1024;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 25) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model(int k);
    string p;
    logic ack, nr, wr, ov, uf, busy;
    logic [15:0] dat, bc;
    if (k == 0) begin
      p = "l_"; ack = l_ack; nr = l_nr; wr = l_wr; ov = l_ov; uf = l_uf; busy = l_busy; dat = l_dat; bc = l_bc;
    end else begin
      p = "s_"; ack = s_ack; nr = s_nr; wr = s_wr; ov = s_ov; uf = s_uf; busy = s_busy; dat = s_dat; bc = s_bc;
    end
    chk({p, "ack"},        32'(ack),  32'(m_burst[k] && !empty));
    chk({p, "nready"},     32'(nr),   32'(!(m_arm[k] || m_burst[k] || m_gap[k])));
    chk({p, "busy"},       32'(busy), 32'(m_burst[k] || m_gap[k]));
    chk({p, "gpif_write"}, 32'(wr),   32'(m_wr[k]));
    chk({p, "gpif_data"},  32'(dat),  32'(m_dat[k]));
    chk({p, "overflow"},   32'(ov),   32'(m_ov[k]));
    chk({p, "underflow"},  32'(uf),   32'(m_uf[k]));
    chk({p, "burst_cnt"},  32'(bc),   32'(m_cnt[k]));
  endtask

  task automatic model_step(int k);
    bit ack;
    ack = m_burst[k] && !empty;
    if (reset) begin
      m_arm[k] = 0; m_burst[k] = 0; m_gap[k] = 0; m_halt[k] = 0; m_ov[k] = 0; m_uf[k] = 0;
      m_wr[k] = 0; m_left[k] = 0; m_cnt[k] = 0; m_pat[k] = 0; m_dat[k] = 0;
      return;
    end
    m_wr[k]  = ack;
    m_dat[k] = tm ? m_pat[k] : int'(fdata);
    if (ack) m_pat[k] = (m_pat[k] + 1) % 1024;
    if (m_arm[k]) begin
      if (full) begin m_arm[k] = 0; m_halt[k] = 1; m_ov[k] = 1; end
      else if (!hc) m_arm[k] = 0;
      else if (hf && dma) begin m_arm[k] = 0; m_burst[k] = 1; m_left[k] = bl[k]; end
    end else if (m_burst[k]) begin
      if (full) m_ov[k] = 1;
      if (empty) m_uf[k] = 1;
      if (ack) begin
        m_left[k]--;
        if (m_left[k] == 0) begin m_burst[k] = 0; m_gap[k] = 1; end
      end
    end else if (m_gap[k]) begin
      m_gap[k] = 0;
      m_cnt[k] = (m_cnt[k] + 1) % 65536;
      if (m_ov[k] || full) begin m_halt[k] = 1; m_ov[k] = 1; end
      else if (hc) begin m_arm[k] = 1; m_pat[k] = 0; end
    end else if (m_halt[k]) begin
      if (!hc) m_halt[k] = 0;
    end else if (hc) begin
      m_arm[k] = 1; m_pat[k] = 0; m_ov[k] = 0; m_uf[k] = 0; m_cnt[k] = 0;
    end
  endtask

  // Inputs are set just after a rising edge; checks run mid-cycle.
  task automatic cycle();
    bit adv;
    if (use_src) fdata = 10'(scr(src));
    #1;
    if (chk_en) begin
      check_model(0);
      check_model(1);
      if (l_wr === 1'b1) begin
        wr_cnt[0]++;
        if (ord_en) begin
          chk("order", 32'(l_dat), 32'(tm ? ord_idx % 1024 : scr(ord_idx)));
          ord_idx++;
        end
      end
      if (s_wr === 1'b1) wr_cnt[1]++;
    end
    adv = m_burst[0] && !empty;
    model_step(0);
    model_step(1);
    if (adv && !reset) src++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(bit h, bit d, bit f, bit fu, bit e);
    hc = h; dma = d; hf = f; full = fu; empty = e;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    wr_cnt = '{0, 0};
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acks;
    tbl[0]  = '{1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 1, 1, 1, 0,  1, 0, 1, 0, 0};
    tbl[4]  = '{0, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0};
    tbl[6]  = '{0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0};
    tbl[7]  = '{0, 0, 1, 1, 0, 0,  1, 0, 0, 0, 0};
    tbl[8]  = '{0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0};
    tbl[9]  = '{0, 1, 1, 1, 0, 0,  0, 1, 0, 0, 1};
    tbl[10] = '{0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 1};
    tbl[11] = '{1, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0};

    chk_en = 0; use_src = 0; ord_en = 0; src = 0; ord_idx = 0; wr_cnt = '{0, 0};
    tm = 0; fdata = '0;
    set_in(0, 0, 0, 0, 0);
    @(posedge clk); #1;
    do_reset();
    chk_en = 1;

    // Arm / halt / priority vectors (small instance)
    for (int i = 0; i < 12; i++) begin
      reset = tbl[i].rst;
      set_in(tbl[i].hc, tbl[i].dma, tbl[i].hf, tbl[i].full, tbl[i].empty);
      cycle();
      chk($sformatf("vec%0d_nready", i), 32'(s_nr),   32'(tbl[i].nr));
      chk($sformatf("vec%0d_ack", i),    32'(s_ack),  32'(tbl[i].ack));
      chk($sformatf("vec%0d_ovf", i),    32'(s_ov),   32'(tbl[i].ov));
      chk($sformatf("vec%0d_unf", i),    32'(s_uf),   32'(tbl[i].uf));
      chk($sformatf("vec%0d_busy", i),   32'(s_busy), 32'(tbl[i].busy));
    end
    reset = 0;
    wr_cnt = '{0, 0};

    // DMA gating, then a full 4096-word burst in FIFO order
    use_src = 1; src = 0; ord_idx = 0; ord_en = 1;
    set_in(1, 0, 1, 0, 0);
    cycle();
    acks = 0;
    repeat (50) begin cycle(); if (l_ack === 1'b1) acks++; end
    chk("gate_noack", 32'(acks), 32'(0));
    dma = 1;
    cycle();
    chk("burst_start", 32'(l_ack), 32'(1));
    dma = 0;
    repeat (4100) cycle();
    chk("burst_writes", 32'(wr_cnt[0]), 32'(4096));
    chk("burst_count1", 32'(l_bc), 32'(1));
    chk("burst_done",   32'(l_busy), 32'(0));

    // Test pattern across two back-to-back bursts
    do_reset();
    tm = 1; ord_idx = 0;
    set_in(1, 0, 1, 0, 0);
    cycle();
    dma = 1;
    for (int i = 0; i < 8400 && wr_cnt[0] < 8192; i++) cycle();
    dma = 0;
    repeat (4) cycle();
    chk("pat_writes", 32'(wr_cnt[0]), 32'(8192));
    chk("pat_bursts", 32'(l_bc), 32'(2));
    tm = 0; ord_en = 0;

    // Overflow inside a burst: finish the burst, then halt; re-arm clears
    do_reset();
    set_in(1, 0, 1, 0, 0); cycle();
    dma = 1; cycle();
    dma = 0; cycle();
    full = 1; cycle();
    full = 0;
    repeat (12) cycle();
    chk("ovf_writes", 32'(wr_cnt[1]), 32'(8));
    chk("ovf_flag",   32'(s_ov), 32'(1));
    chk("ovf_halt",   32'(s_nr), 32'(1));
    hc = 0; cycle();
    hc = 1; cycle();
    chk("ovf_rearm_clear",  32'(s_ov), 32'(0));
    chk("ovf_rearm_nready", 32'(s_nr), 32'(0));

    // Underflow: three empty cycles mid-burst
    do_reset();
    set_in(1, 0, 1, 0, 0); cycle();
    dma = 1; cycle();
    dma = 0;
    repeat (3) cycle();
    empty = 1;
    repeat (3) cycle();
    empty = 0;
    repeat (10) cycle();
    chk("unf_writes", 32'(wr_cnt[1]), 32'(8));
    chk("unf_flag",   32'(s_uf), 32'(1));
    chk("unf_done",   32'(s_busy), 32'(0));

    // Disarm mid-burst: burst completes, then idle
    do_reset();
    set_in(1, 0, 1, 0, 0); cycle();
    dma = 1; cycle();
    hc = 0; dma = 0;
    repeat (12) cycle();
    chk("disarm_writes", 32'(wr_cnt[1]), 32'(8));
    chk("disarm_idle",   32'(s_nr), 32'(1));
    chk("disarm_count",  32'(s_bc), 32'(1));

    // Reset at word 100 of a long burst
    do_reset();
    set_in(1, 0, 1, 0, 0); cycle();
    dma = 1; cycle();
    repeat (100) cycle();
    chk("pre_reset_ack", 32'(l_ack), 32'(1));
    reset = 1; cycle();
    chk("rst_ack",    32'(l_ack), 32'(0));
    chk("rst_write",  32'(l_wr),  32'(0));
    chk("rst_nready", 32'(l_nr),  32'(1));
    chk("rst_count",  32'(l_bc),  32'(0));
    reset = 0;

    // Randomised traffic against the model
    use_src = 0;
    repeat (3000) begin
      reset = ($urandom_range(0, 1499) == 0);
      hc    = ($urandom_range(0, 19) != 0);
      dma   = ($urandom_range(0, 9) < 7);
      hf    = ($urandom_range(0, 9) < 6);
      full  = ($urandom_range(0, 59) == 0);
      empty = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 99) == 0) tm = ~tm;
      fdata = 10'($urandom);
      cycle();
    end
    reset = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/capture_transfer_scheduler.md
Name: capture_transfer_scheduler

Overview:
- Read-side controller for the 8192x10 capture DCFIFO wrapper. It arms and disarms sample collection and waits for half-full plus host DMA-ready.
- It then drains fixed-length bursts onto the FX3 GPIF 16-bit bus, detects overflow and underflow, and counts completed bursts.
- Sits between the FIFO wrapper's read port and the GPIF interface. It runs entirely in the read-clock domain.

Parameters:
- BURST_LEN, 4096: words per burst. Legal range 1..4096; the FIFO's >4096 half-full threshold guarantees no underflow at ≤4096.
- COUNT_W, 16: width of burstCount (wraps).

Ports:
- outputClock  in  1  FIFO read-side clock; the only clock.
- reset  in  1  synchronous, active-high.
- hostCollect  in  1  host requests capture (already synchronised).
- testMode  in  1  1 = send a 10-bit counter pattern instead of FIFO data.
- dmaReady  in  1  FX3 DMA buffer available.
- fifoData  in  10  FIFO show-ahead output.
- fifoEmpty  in  1  FIFO empty_flag.
- fifoHalfFull  in  1  FIFO halfFull_flag.
- fifoFull  in  1  FIFO full_flag.
- fifoAck  out  1  FIFO read acknowledge (pop).
- fifoNReady  out  1  FIFO nReady: 0 = collect, 1 = hold FIFO cleared.
- gpifData  out  16  {6'b0, sample}.
- gpifWrite  out  1  gpifData valid this cycle.
- overflow  out  1  sticky FIFO-full error.
- underflow  out  1  sticky empty-during-burst error.
- busy  out  1  state is BURST or END.
- burstCount  out  COUNT_W  completed bursts since reset or re-arm.

Behaviour:
- Reset values: state IDLE, fifoAck 0, fifoNReady 1, gpifData 0, gpifWrite 0, overflow 0, underflow 0, burstCount 0, wordCount 0, pattern counter 0.
- Reset mid-burst aborts immediately; no further writes are issued.
- IDLE:
  - fifoNReady = 1.
  - When hostCollect = 1: go to ARM, clear overflow, underflow and burstCount.
- ARM:
  - fifoNReady = 0.
  - If fifoFull: go to HALT.
  - Else if hostCollect = 0: go to IDLE.
  - Else if fifoHalfFull && dmaReady (sampled in the same cycle): go to BURST, wordCount = 0.
- BURST:
  - fifoNReady = 0.
  - fifoAck = !fifoEmpty (combinational on state and fifoEmpty).
  - Each acked cycle increments wordCount.
  - fifoEmpty = 1 in BURST: no ack that cycle, underflow set (sticky), stay in BURST until the word count completes.
  - When the ack is taken with wordCount == BURST_LEN-1: go to END.
  - dmaReady and hostCollect are ignored once BURST is entered. A burst is never truncated.
  - fifoFull in BURST: set overflow, finish the burst, then go to HALT from END.
- END:
  - One-cycle gap: no ack, gpifWrite drops after the pipeline drains.
  - burstCount += 1 (wraps).
  - Next state: HALT if overflow, else ARM if hostCollect, else IDLE.
- HALT:
  - fifoNReady = 1 (FIFO aclr).
  - Hold overflow = 1 until hostCollect = 0, then go to IDLE.
- Datapath (1-cycle registered latency):
  - gpifWrite(t+1) = fifoAck(t).
  - gpifData(t+1) = {6'b0, testMode ? pattern : fifoData}, sampled at t.
  - pattern increments on every ack, wraps 1023→0, and resets to 0 on entering ARM.
- Simultaneous events:
  - fifoFull and the start condition in the same ARM cycle: HALT wins.
  - hostCollect falling in the same cycle as a burst start in ARM: IDLE wins.
- Invariant: gpifWrite pulses per burst == BURST_LEN exactly.

Decomposition:
- Shared package (capture_pkg):
  - state enum {IDLE, ARM, BURST, END, HALT}.
  - FIFO_DEPTH = 8192.
  - HALF_FULL_LEVEL = 4096.
  - GPIF_W = 16.
  - SAMPLE_W = 10.
- One natural sub-module: gpif_output_stage, the registered data/valid pipeline plus test-pattern counter. The FSM and counters stay in the top.

Test Plan:
- Normal burst (BURST_LEN = 4096, hostCollect = 1, dmaReady = 1): assert fifoHalfFull with non-empty data.
  - Exactly 4096 gpifWrite pulses, one cycle after the 4096 acks.
  - Data matches FIFO order.
  - 1-cycle gap, burstCount = 1.
- Test pattern (testMode = 1, two back-to-back bursts): gpifData = 0,1,…,1023,0,… continuing across the burst boundary; burstCount = 2.
- DMA gating: fifoHalfFull = 1 with dmaReady = 0 for 50 cycles → no fifoAck. Raise dmaReady → burst starts next cycle.
  - Dropping dmaReady mid-burst does not stop it.
- Overflow: pulse fifoFull during ARM → HALT, fifoNReady = 1, overflow = 1.
  - hostCollect = 0 → IDLE. Re-arm clears overflow.
- Underflow (BURST_LEN = 8): force fifoEmpty = 1 for 3 cycles mid-burst → acks pause, underflow = 1, still 8 writes total.
- Disarm and reset:
  - hostCollect = 0 mid-burst → burst completes, then IDLE.
  - reset = 1 at word 100 → next cycle fifoAck = 0, gpifWrite = 0, fifoNReady = 1, burstCount = 0.
